// File: rtl/playback_pkg.sv
// ----------------------------------------------------------------------------
// playback_pkg
// Shared definitions for the sample playback controller: controller state
// encoding, ASCII key codes, decoded key commands and the key decoder.
// ----------------------------------------------------------------------------
package playback_pkg;

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_PLAYING = 2'd1,
      ST_RESTART = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE    = 3'd0,
      CMD_PLAY    = 3'd1,
      CMD_STOP    = 3'd2,
      CMD_FWD     = 3'd3,
      CMD_BWD     = 3'd4,
      CMD_RESTART = 3'd5
   } cmd_t;

   // Upper-case ASCII codes of the command keys.
   localparam logic [7:0] KEY_PLAY    = 8'h45;  // 'E'
   localparam logic [7:0] KEY_STOP    = 8'h44;  // 'D'
   localparam logic [7:0] KEY_FWD     = 8'h46;  // 'F'
   localparam logic [7:0] KEY_BWD     = 8'h42;  // 'B'
   localparam logic [7:0] KEY_RESTART = 8'h52;  // 'R'

   // Lower-case letters differ from upper-case only in this bit.
   localparam logic [7:0] CASE_MASK   = 8'hDF;

   // Clearing the case bit folds 'e' onto 'E'; the only codes that fold onto
   // one of the five command letters are that letter's two cases, so every
   // other code still decodes to CMD_NONE.
   function automatic cmd_t decode_key(input logic [7:0] ascii);
      logic [7:0] folded;
      folded = ascii & CASE_MASK;
      case (folded)
         KEY_PLAY:    return CMD_PLAY;
         KEY_STOP:    return CMD_STOP;
         KEY_FWD:     return CMD_FWD;
         KEY_BWD:     return CMD_BWD;
         KEY_RESTART: return CMD_RESTART;
         default:     return CMD_NONE;
      endcase
   endfunction

endpackage

// File: rtl/rate_divider.sv
// ----------------------------------------------------------------------------
// rate_divider
// Sample-rate strobe generator. While enabled it counts clk cycles and emits
// a one-cycle trigger every `divisor` cycles; while disabled the count is held
// at zero so the first trigger arrives `divisor` cycles after enable rises.
//
// Ports
//   clk      in   clock, all logic on posedge
//   reset    in   synchronous active-high reset
//   enable   in   count while high, clear while low
//   divisor  in   trigger period in clk cycles (>= 1)
//   trigger  out  registered one-cycle strobe
// ----------------------------------------------------------------------------
module rate_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] divisor,
   output logic        trigger
);

   logic [15:0] count;

   // The >= compare (rather than ==) makes a divisor that shrinks below the
   // running count fire straight away instead of wrapping through 65535.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         trigger <= 1'b0;
      end else if (!enable) begin
         count   <= '0;
         trigger <= 1'b0;
      end else if (count >= 16'(divisor - 16'd1)) begin
         count   <= '0;
         trigger <= 1'b1;
      end else begin
         count   <= count + 16'd1;
         trigger <= 1'b0;
      end
   end

endmodule

// File: rtl/playback_ctrl.sv
// ----------------------------------------------------------------------------
// playback_ctrl
// Keyboard-driven transport control for a sample player. Decodes PS/2 ASCII
// keys into play / stop / forward / backward / restart, keeps the adjustable
// sample-rate divisor and drives the rate_divider that paces playback.
//
// Ports
//   clk            in   clock, all logic on posedge
//   reset          in   synchronous active-high reset
//   key_valid      in   one-cycle strobe, key_ascii valid
//   key_ascii[7:0] in   ASCII code of a decoded key
//   speed_up       in   pulse, shorten trigger period by DIV_STEP
//   speed_down     in   pulse, lengthen trigger period by DIV_STEP
//   speed_reset    in   pulse, restore DEFAULT_DIV
//   play_enabled   out  high only while PLAYING
//   direction      out  1 = forward, 0 = backward
//   reset_address  out  one-cycle pulse, reload player address
//   reset_to_end   out  with reset_address: 1 = end address, 0 = address 0
//   trigger        out  one-cycle sample-rate strobe
//   divisor[15:0]  out  current trigger period in clk cycles
// ----------------------------------------------------------------------------
module playback_ctrl
   import playback_pkg::*;
#(
   parameter int unsigned DEFAULT_DIV = 2272,
   parameter int unsigned DIV_STEP    = 64,
   parameter int unsigned DIV_MIN     = 256,
   parameter int unsigned DIV_MAX     = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [7:0]  key_ascii,
   input  logic        speed_up,
   input  logic        speed_down,
   input  logic        speed_reset,
   output logic        play_enabled,
   output logic        direction,
   output logic        reset_address,
   output logic        reset_to_end,
   output logic        trigger,
   output logic [15:0] divisor
);

   localparam logic [15:0] DEF_W  = 16'(DEFAULT_DIV);
   localparam logic [16:0] STEP_W = 17'(DIV_STEP);
   localparam logic [16:0] MIN_W  = 17'(DIV_MIN);
   localparam logic [16:0] MAX_W  = 17'(DIV_MAX);

   state_t      state, state_next;
   logic        prior_playing, prior_playing_next;
   logic        direction_next;
   logic        reset_address_next, reset_to_end_next;
   logic [15:0] divisor_next;
   logic [16:0] div_sum;
   logic        div_enable;
   cmd_t        cmd;

   assign cmd = key_valid ? decode_key(key_ascii) : CMD_NONE;

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next         = state;
      prior_playing_next = prior_playing;
      direction_next     = direction;
      reset_address_next = 1'b0;
      reset_to_end_next  = 1'b0;

      unique case (state)
         ST_STOPPED, ST_PLAYING: begin
            case (cmd)
               CMD_PLAY: state_next     = ST_PLAYING;
               CMD_STOP: state_next     = ST_STOPPED;
               CMD_FWD:  direction_next = 1'b1;
               CMD_BWD:  direction_next = 1'b0;
               CMD_RESTART: begin
                  state_next         = ST_RESTART;
                  prior_playing_next = (state == ST_PLAYING);
                  reset_address_next = 1'b1;
                  // Backward playback starts from the end of the buffer.
                  reset_to_end_next  = ~direction;
               end
               default: ;
            endcase
         end
         // One-cycle stay; keys are dropped while here.
         ST_RESTART: state_next = prior_playing ? ST_PLAYING : ST_STOPPED;
         default:    state_next = ST_STOPPED;
      endcase
   end

   // Divisor update, computed one bit wider so the step saturates instead of
   // wrapping. Opposing up/down pulses cancel; speed_reset wins over both.
   always_comb begin
      div_sum      = {1'b0, divisor} + STEP_W;
      divisor_next = divisor;
      if (speed_reset) begin
         divisor_next = DEF_W;
      end else if (speed_up && !speed_down) begin
         divisor_next = ({1'b0, divisor} < MIN_W + STEP_W) ? MIN_W[15:0]
                                                           : divisor - STEP_W[15:0];
      end else if (speed_down && !speed_up) begin
         divisor_next = (div_sum > MAX_W) ? MAX_W[15:0] : div_sum[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_STOPPED;
         prior_playing <= 1'b0;
         direction     <= 1'b1;
         divisor       <= DEF_W;
         play_enabled  <= 1'b0;
         reset_address <= 1'b0;
         reset_to_end  <= 1'b0;
      end else begin
         state         <= state_next;
         prior_playing <= prior_playing_next;
         direction     <= direction_next;
         divisor       <= divisor_next;
         play_enabled  <= (state_next == ST_PLAYING);
         reset_address <= reset_address_next;
         reset_to_end  <= reset_to_end_next;
      end
   end

   // Counting waits for play_enabled to be high (so the first trigger lands
   // `divisor` cycles after it rises) and stops on the edge that leaves
   // PLAYING, so no trigger can appear in a STOPPED or RESTART cycle.
   assign div_enable = play_enabled && (state_next == ST_PLAYING);

   rate_divider u_rate_divider (
      .clk     (clk),
      .reset   (reset),
      .enable  (div_enable),
      .divisor (divisor),
      .trigger (trigger)
   );

endmodule

// File: tb/tb_playback_ctrl.sv
// ----------------------------------------------------------------------------
// tb_playback_ctrl
// Scoreboard bench for playback_ctrl. The driver applies one input vector per
// cycle at the falling edge, advances a behavioural model of the controller
// and queues the outputs expected after the next rising edge. A separate
// monitor pops one expectation per cycle shortly after each rising edge and
// compares it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_playback_ctrl;

   localparam int DEF  = 2272;
   localparam int STEP = 64;
   localparam int DMIN = 256;
   localparam int DMAX = 65535;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        key_valid = 1'b0;
   logic [7:0]  key_ascii = 8'h00;
   logic        speed_up = 1'b0;
   logic        speed_down = 1'b0;
   logic        speed_reset = 1'b0;
   logic        play_enabled, direction, reset_address, reset_to_end, trigger;
   logic [15:0] divisor;

   always #5 clk = ~clk;

   playback_ctrl #(
      .DEFAULT_DIV (DEF),
      .DIV_STEP    (STEP),
      .DIV_MIN     (DMIN),
      .DIV_MAX     (DMAX)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .key_valid     (key_valid),
      .key_ascii     (key_ascii),
      .speed_up      (speed_up),
      .speed_down    (speed_down),
      .speed_reset   (speed_reset),
      .play_enabled  (play_enabled),
      .direction     (direction),
      .reset_address (reset_address),
      .reset_to_end  (reset_to_end),
      .trigger       (trigger),
      .divisor       (divisor)
   );

   // {play_enabled, direction, reset_address, reset_to_end, trigger, divisor}
   typedef logic [20:0] obs_t;

   obs_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic check(input string name, input obs_t got, input obs_t want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s t=%0t got pe/dir/ra/rte/trg=%b div=%0d  want pe/dir/ra/rte/trg=%b div=%0d",
                    name, $time, got[20:16], got[15:0], want[20:16], want[15:0]);
   endtask

   // ---------------- behavioural reference model ----------------
   // mode: 0 = stopped, 1 = playing, 2 = restart
   int m_mode  = 0;
   int m_prior = 0;
   bit m_dir   = 1'b1;
   int m_div   = DEF;
   int m_run   = 0;   // enabled cycles since playback started or last trigger
   bit m_pe    = 1'b0;

   function automatic obs_t model_step(input bit rst, input bit kv, input logic [7:0] asc,
                                       input bit up, input bit dn, input bit sr);
      int         nmode;
      int         ndiv;
      bit         ndir, ra, rte, trg;
      logic [7:0] k;
      if (rst) begin
         m_mode = 0; m_prior = 0; m_dir = 1'b1; m_div = DEF; m_run = 0; m_pe = 1'b0;
         return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'(DEF)};
      end
      nmode = m_mode; ndir = m_dir; ra = 1'b0; rte = 1'b0; trg = 1'b0;
      k = asc;
      if (k >= 8'h61 && k <= 8'h7A) k = k - 8'h20;  // to upper case
      if (m_mode == 2) begin
         nmode = m_prior;
      end else if (kv) begin
         case (k)
            8'h45: nmode = 1;          // E
            8'h44: nmode = 0;          // D
            8'h46: ndir  = 1'b1;       // F
            8'h42: ndir  = 1'b0;       // B
            8'h52: begin               // R
               m_prior = m_mode; nmode = 2; ra = 1'b1; rte = !m_dir;
            end
            default: ;
         endcase
      end
      // A trigger fires once `divisor` enabled cycles have elapsed, judged
      // against the divisor in force before this edge.
      if (m_pe && nmode == 1) begin
         m_run++;
         if (m_run >= m_div) begin trg = 1'b1; m_run = 0; end
      end else begin
         m_run = 0;
      end
      ndiv = m_div;
      if (sr)              ndiv = DEF;
      else if (up && !dn)  ndiv = (m_div - STEP < DMIN) ? DMIN : m_div - STEP;
      else if (dn && !up)  ndiv = (m_div + STEP > DMAX) ? DMAX : m_div + STEP;
      m_mode = nmode; m_dir = ndir; m_div = ndiv; m_pe = (nmode == 1);
      return {m_pe, m_dir, ra, rte, trg, 16'(m_div)};
   endfunction

   // ---------------- driver helpers ----------------
   task automatic drive(input bit rst, input bit kv, input logic [7:0] asc,
                        input bit up, input bit dn, input bit sr);
      @(negedge clk);
      reset = rst; key_valid = kv; key_ascii = asc;
      speed_up = up; speed_down = dn; speed_reset = sr;
      exp_q.push_back(model_step(rst, kv, asc, up, dn, sr));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic key(input logic [7:0] c);
      drive(1'b0, 1'b1, c, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0)
            check("cycle", {play_enabled, direction, reset_address, reset_to_end, trigger, divisor},
                  exp_q.pop_front());
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] key_pool [16] = '{8'h45, 8'h65, 8'h44, 8'h64, 8'h46, 8'h66, 8'h42, 8'h62,
                                 8'h52, 8'h72, 8'h78, 8'h58, 8'h37, 8'h20, 8'hC5, 8'h05};

   initial begin
      // Reset, play at default rate: two full periods of triggers.
      do_reset(); do_reset();
      key(8'h45);
      idle(2 * DEF + 20);

      // Backward, then lower-case restart while playing.
      key(8'h42);
      idle(300);
      key(8'h72);
      idle(30);

      // Divisor shrink mid-count: ~1000 counts at 2272, then 20 speed_ups.
      do_reset();
      key(8'h45);
      idle(1000);
      for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(5);

      // Saturation at the minimum, then play at the fastest rate.
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 41; i++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle(600);

      // Opposing pulses cancel; speed_reset beats speed_down.
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      idle(3);

      // Reset during RESTART, then an unknown key and stop while stopped.
      key(8'h62);
      key(8'h52);
      do_reset();
      key(8'h78);
      key(8'h44);
      idle(3);

      // Keys during RESTART are dropped; stopped restart returns to stopped.
      key(8'h52);
      key(8'h45);
      idle(3);

      // Saturation at the maximum.
      for (int i = 0; i < 1000; i++) drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      idle(3);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Randomised phase, biased toward faster rates so triggers are frequent.
      for (int i = 0; i < 7000; i++) begin
         bit         rst, kv, up, dn, sr;
         logic [7:0] asc;
         rst = ($urandom_range(0, 1499) == 0);
         kv  = ($urandom_range(0, 39) == 0);
         asc = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                           : key_pool[$urandom_range(0, 15)];
         up  = ($urandom_range(0, 24) == 0);
         dn  = ($urandom_range(0, 59) == 0);
         sr  = ($urandom_range(0, 799) == 0);
         drive(rst, kv, asc, up, dn, sr);
      end

      // Drain: the monitor must have consumed every expectation.
      repeat (3) @(negedge clk);
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain pending=%0d want=0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/playback_ctrl.md
PLAYBACK_CTRL -- requirements
Module: playback_ctrl

Interface
REQ-001 Parameter DEFAULT_DIV, 2272, trigger period in clk cycles after reset (50 MHz / 22 kHz).
REQ-002 Parameter DIV_STEP, 64, divisor change per speed command.
REQ-003 Parameter DIV_MIN, 256, lowest legal divisor.
REQ-004 Parameter DIV_MAX, 65535, highest legal divisor.
REQ-005 clk  input  1  sole clock; all logic on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 key_valid  input  1  one-cycle strobe; key_ascii is valid this cycle.
REQ-008 key_ascii  input  8  ASCII code of a decoded PS/2 key.
REQ-009 speed_up  input  1  one-cycle pulse; shortens the trigger period.
REQ-010 speed_down  input  1  one-cycle pulse; lengthens the trigger period.
REQ-011 speed_reset  input  1  one-cycle pulse; restores DEFAULT_DIV.
REQ-012 play_enabled  output  1  level; player may fetch and emit samples.
REQ-013 direction  output  1  level; 1 = forward, 0 = backward.
REQ-014 reset_address  output  1  one-cycle pulse; reloads the player address.
REQ-015 reset_to_end  output  1  qualifies reset_address; 1 = load end address, 0 = load address 0.
REQ-016 trigger  output  1  one-cycle sample-rate strobe.
REQ-017 divisor  output  16  current trigger period in clk cycles.

Function
REQ-018 The controller SHALL implement the states STOPPED, PLAYING and RESTART, plus a registered prior-state flag.
REQ-019 Key decoding SHALL be case-insensitive: E/e = play, D/d = stop, F/f = forward, B/b = backward, R/r = restart; all other codes SHALL be ignored.
REQ-020 In STOPPED, E SHALL move to PLAYING on the next edge; D SHALL have no effect.
REQ-021 In PLAYING, D SHALL move to STOPPED on the next edge; E SHALL have no effect.
REQ-022 F and B SHALL set direction on the next edge in any state other than RESTART, without changing state.
REQ-023 In STOPPED or PLAYING, R SHALL enter RESTART, record the prior state, and drive reset_address=1 for exactly one cycle with reset_to_end = ~direction.
REQ-024 RESTART SHALL last one cycle and then return to the recorded prior state; keys arriving during RESTART SHALL be ignored.
REQ-025 play_enabled SHALL be 1 only in PLAYING; it SHALL be 0 in STOPPED and RESTART.
REQ-026 reset_to_end SHALL be 0 whenever reset_address is 0.
REQ-027 The trigger counter SHALL be 16 bits and SHALL count only while play_enabled=1.
REQ-028 When counter >= divisor-1, trigger SHALL pulse for one cycle and the counter SHALL return to 0 (the >= compare protects against a divisor shrink mid-count).
REQ-029 In STOPPED and RESTART, the counter SHALL be held at 0 and trigger SHALL be 0.
REQ-030 The first trigger after entering PLAYING SHALL occur divisor cycles after play_enabled rises.
REQ-031 speed_up SHALL set divisor = max(divisor-DIV_STEP, DIV_MIN); speed_down SHALL set divisor = min(divisor+DIV_STEP, DIV_MAX). Both SHALL saturate and never wrap.
REQ-032 Speed priority SHALL be: speed_reset first; speed_up together with speed_down SHALL leave divisor unchanged.
REQ-033 A divisor change SHALL take effect on the next compare with no pipeline delay.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 On reset=1, at the next edge: state=STOPPED, direction=1, divisor=DEFAULT_DIV, counter=0, play_enabled=0, trigger=0, reset_address=0, reset_to_end=0.
REQ-036 Reset SHALL override all simultaneous inputs, including asserting reset during RESTART or during a trigger cycle.

Structure
REQ-037 A shared package playback_pkg SHALL hold the state enum and the ASCII key constants.
REQ-038 The divider SHALL be one sub-module, rate_divider: inputs clk, reset, enable, divisor; output trigger.

Verification
REQ-039 Reset, then 'E', with default divisor -> play_enabled=1 one cycle later; triggers exactly every 2272 cycles.
REQ-040 While PLAYING, direction=0, send 'r' -> one-cycle reset_address=1 with reset_to_end=1; play_enabled low for that cycle, then back to 1; counter restarts.
REQ-041 Pulse speed_up 40 times from 2272 -> divisor saturates at 256; one more speed_up -> divisor stays 256.
REQ-042 Assert speed_up and speed_down together, then speed_reset together with speed_down -> divisor unchanged, then 2272.
REQ-043 At divisor=2272 with counter=1000, pulse speed_up 20 times -> divisor=992, trigger fires on the next cycle, counter resets to 0.
REQ-044 Assert reset during RESTART -> next cycle: STOPPED, reset_address=0, direction=1; 'x' and 'D' while STOPPED -> no output change.
